// File: rtl/freq_meter_if.sv
// Control/result bundle for freq_meter. The optional mode signal exists only
// when FREQ_METER_PERIOD_EN is defined.
interface freq_meter_if #(
  parameter int CNT_WIDTH = 32
);
  // start is a level request taken only while the meter is idle; there is no
  // ready, and a request seen in any other state is dropped. done is a one-cycle
  // strobe; count/overflow are valid with it and hold until the next done.
  logic                 start;
`ifdef FREQ_METER_PERIOD_EN
  logic                 mode;
`endif
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;

`ifdef FREQ_METER_PERIOD_EN
  modport master (output start, output mode, input busy, input done, input count, input overflow);
  modport slave  (input start, input mode, output busy, output done, output count, output overflow);
`else
  modport master (output start, input busy, input done, input count, input overflow);
  modport slave  (input start, output busy, output done, output count, output overflow);
`endif
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter measuring sig_in against clk_in over GATE_CYCLES cycles.
// FREQ_METER_PERIOD_EN adds an edge-to-edge period mode selected by bus.mode.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         sig_in,
  freq_meter_if.slave  bus,
  output logic [2:0]   fsm_state
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]        GATE_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GATE      = 3'd1,
    S_DONE      = 3'd2,
    S_WAIT_EDGE = 3'd3,
    S_PERIOD    = 3'd4
  } state_t;

  state_t               state, state_next;
  logic                 s1, s2, d;
  logic                 rise;
  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 ovf_flag;
  logic                 gate_last;
  logic                 cnt_sat;

  assign rise      = s2 & ~d;
  assign gate_last = (gate_cnt == GATE_LAST);
  assign cnt_sat   = &edge_cnt;
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef FREQ_METER_PERIOD_EN
          state_next = bus.mode ? S_WAIT_EDGE : S_GATE;
`else
          state_next = S_GATE;
`endif
        end
      end
      S_GATE: if (gate_last) state_next = S_DONE;
`ifdef FREQ_METER_PERIOD_EN
      S_WAIT_EDGE: begin
        if (gate_last)  state_next = S_DONE;
        else if (rise)  state_next = S_PERIOD;
      end
      // A closing edge in the last timeout cycle still completes the period.
      S_PERIOD: if (rise || gate_last) state_next = S_DONE;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= S_IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      d            <= 1'b0;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      ovf_flag     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      d     <= s2;
      state <= state_next;

      // Outputs are registered, so they trail the state by one cycle.
      bus.busy <= (state != S_IDLE);
      bus.done <= (state == S_DONE);
      if (state == S_DONE) begin
        bus.count    <= edge_cnt;
        bus.overflow <= ovf_flag;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
          end
        end
        S_GATE: begin
          gate_cnt <= gate_cnt + GATE_ONE;
          if (rise) begin
            if (cnt_sat) ovf_flag <= 1'b1;
            else         edge_cnt <= edge_cnt + CNT_ONE;
          end
        end
`ifdef FREQ_METER_PERIOD_EN
        S_WAIT_EDGE: begin
          gate_cnt <= gate_cnt + GATE_ONE;
          if (gate_last) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b1;
          end
        end
        S_PERIOD: begin
          gate_cnt <= gate_cnt + GATE_ONE;
          if (!rise && gate_last) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b1;
          end else if (cnt_sat) begin
            ovf_flag <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + CNT_ONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: an 8-bit and a 5-bit instance share sig_in;
// expected results are queued at start and checked when done pulses.
module tb_freq_meter;

  localparam int W = 17;

  logic clk = 1'b0;
  logic reset;
  logic sig_in;
  logic [2:0] st8_dbg, st5_dbg;

  freq_meter_if #(.CNT_WIDTH(8)) bus8 ();
  freq_meter_if #(.CNT_WIDTH(5)) bus5 ();

  freq_meter #(.GATE_CYCLES(100), .CNT_WIDTH(8)) u8 (
    .clk_in(clk), .reset(reset), .sig_in(sig_in), .bus(bus8), .fsm_state(st8_dbg)
  );
  freq_meter #(.GATE_CYCLES(100), .CNT_WIDTH(5)) u5 (
    .clk_in(clk), .reset(reset), .sig_in(sig_in), .bus(bus5), .fsm_state(st5_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int st8 = 0, st5 = 0;
  int busy_len8 = 0, busy_len5 = 0;
  logic [W-1:0] exp8_q[$];
  logic [W-1:0] exp5_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic compare_result(input string tag, input logic [W-1:0] e,
                                input int cnt, input logic ovf, input int lat, input int blen);
    check({tag, "_count"}, cnt, e[15:8]);
    check({tag, "_overflow"}, ovf, e[16]);
    if (e[7:0] != 8'd0) begin
      check({tag, "_latency"}, lat, e[7:0]);
      check({tag, "_busy_len"}, blen, e[7:0]);
    end
  endtask

  // Monitor: pops one expectation per done pulse of each instance.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      busy_len8 = 0;
      busy_len5 = 0;
    end else begin
      if (bus8.busy) busy_len8++;
      if (bus5.busy) busy_len5++;
      if (bus8.done) begin
        check("u8_done_expected", exp8_q.size() > 0, 1);
        if (exp8_q.size() > 0) begin
          e = exp8_q.pop_front();
          compare_result("u8", e, int'(bus8.count), bus8.overflow, cyc - st8 - 1, busy_len8);
        end
        busy_len8 = 0;
      end
      if (bus5.done) begin
        check("u5_done_expected", exp5_q.size() > 0, 1);
        if (exp5_q.size() > 0) begin
          e = exp5_q.pop_front();
          compare_result("u5", e, int'(bus5.count), bus5.overflow, cyc - st5 - 1, busy_len5);
        end
        busy_len5 = 0;
      end
    end
  end

  // One measurement: k = 0 is the cycle whose closing edge samples start.
  // per = 0 holds sig_in at 'hold'; otherwise the first rise is at k = 3.
  task automatic measure(input bit sel5, input int per, input bit hold, input bit md,
                         input int xs0, input int xs1, input int xs2, input int abort_at,
                         input bit push, input int e_cnt, input bit e_ovf, input int e_lat);
    logic s;
    for (int k = -5; k < 120; k++) begin
      @(negedge clk);
      if (per == 0) sig_in = hold;
      else          sig_in = (((k + 3 * per - 3) % per) < (per / 2));
      s = (k == 0) || (k == xs0) || (k == xs1) || (k == xs2);
      bus8.start = sel5 ? 1'b0 : s;
      bus5.start = sel5 ? s : 1'b0;
`ifdef FREQ_METER_PERIOD_EN
      bus8.mode = md;
      bus5.mode = md;
`endif
      reset = (k == abort_at);
      if (k == 0) begin
        if (sel5) st5 = cyc;
        else      st8 = cyc;
        if (push) begin
          if (sel5) exp5_q.push_back({e_ovf, e_cnt[7:0], e_lat[7:0]});
          else      exp8_q.push_back({e_ovf, e_cnt[7:0], e_lat[7:0]});
        end
      end
      if (k == abort_at + 1) begin
        check("abort_busy", bus8.busy, 0);
        check("abort_done", bus8.done, 0);
        check("abort_count", bus8.count, 0);
        check("abort_overflow", bus8.overflow, 0);
        check("abort_state", st8_dbg, 0);
        check("abort_u5_count", bus5.count, 0);
      end
    end
    bus8.start = 1'b0;
    bus5.start = 1'b0;
    reset      = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sig_in     = 1'b0;
    bus8.start = 1'b0;
    bus5.start = 1'b0;
`ifdef FREQ_METER_PERIOD_EN
    bus8.mode = 1'b0;
    bus5.mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", bus8.busy, 0);
    check("reset_done", bus8.done, 0);
    check("reset_count", bus8.count, 0);
    check("reset_overflow", bus8.overflow, 0);
    check("reset_u5_count", bus5.count, 0);

    // period 10, first rise 3 cycles after start: 10 edges, done at +101
    measure(1'b0, 10, 1'b0, 1'b0, -100, -100, -100, -100, 1'b1, 10, 1'b0, 101);
    // constant high, then constant low: no edges
    measure(1'b0, 0, 1'b1, 1'b0, -100, -100, -100, -100, 1'b1, 0, 1'b0, 101);
    measure(1'b0, 0, 1'b0, 1'b0, -100, -100, -100, -100, 1'b1, 0, 1'b0, 101);
    // 5-bit counter: 50 rises saturate at 31, then a clean run clears overflow
    measure(1'b1, 2, 1'b0, 1'b0, -100, -100, -100, -100, 1'b1, 31, 1'b1, 101);
    measure(1'b1, 10, 1'b0, 1'b0, -100, -100, -100, -100, 1'b1, 10, 1'b0, 101);
    // extra starts during GATE (20, 99) and DONE (101) are ignored
    measure(1'b0, 10, 1'b0, 1'b0, 20, 99, 101, -100, 1'b1, 10, 1'b0, 101);
    // reset at gate cycle 50 aborts with no done
    measure(1'b0, 10, 1'b0, 1'b0, -100, -100, -100, 50, 1'b0, 0, 1'b0, 0);
`ifdef FREQ_METER_PERIOD_EN
    // period mode: edge-to-edge distance, and timeout with no edges
    measure(1'b0, 37, 1'b0, 1'b1, -100, -100, -100, -100, 1'b1, 37, 1'b0, 0);
    measure(1'b0, 0, 1'b0, 1'b1, -100, -100, -100, -100, 1'b1, 0, 1'b1, 101);
`endif

    repeat (5) @(negedge clk);
    check("u8_all_done_seen", exp8_q.size(), 0);
    check("u5_all_done_seen", exp5_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
